// File: rtl/clock_pkg.sv
// Shared constants and types for the time-setting front end.
// Field limits, AM/PM codes, the per-button FSM state type and a wrap helper.
package clock_pkg;

  localparam logic [5:0] MAX_SECS    = 6'd59;
  localparam logic [5:0] MAX_MINS    = 6'd59;
  localparam logic [5:0] MAX_HOURS24 = 6'd23;

  localparam logic [1:0] AP_AM = 2'b00;
  localparam logic [1:0] AP_PM = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } set_state_t;

  function automatic logic [5:0] wrap_inc(input logic [5:0] val, input logic [5:0] max_val);
    return (val >= max_val) ? 6'd0 : val + 6'd1;
  endfunction

endpackage

// File: rtl/set_field_fsm.sv
// Press detect plus hold/auto-repeat timing for one set button.
// The inc_o output is a single-cycle increment request for the owning field.
module set_field_fsm
  import clock_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic btn,
  output logic inc_o
);

  localparam int unsigned MaxCycles = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam logic [CntW-1:0] HoldLast   = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] RepeatLast = CntW'(REPEAT_CYCLES - 1);

  set_state_t      r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic            r_btn_q;
  logic            w_press;

  assign w_press = btn & ~r_btn_q;

  // btn_q resets high so a button held through reset must be released first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_btn_q <= 1'b1;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_btn_q <= btn;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    inc_o     = 1'b0;
    if (!enable) begin
      w_state_d = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_press) begin
            inc_o     = 1'b1;
            w_cnt_d   = '0;
            w_state_d = HOLD;
          end
        end
        HOLD: begin
          if (!btn) begin
            w_state_d = IDLE;
          end else if (r_cnt == HoldLast) begin
            inc_o     = 1'b1;
            w_cnt_d   = '0;
            w_state_d = REPEAT;
          end else begin
            w_cnt_d = r_cnt + CntW'(1);
          end
        end
        REPEAT: begin
          if (!btn) begin
            w_state_d = IDLE;
          end else if (r_cnt == RepeatLast) begin
            inc_o   = 1'b1;
            w_cnt_d = '0;
          end else begin
            w_cnt_d = r_cnt + CntW'(1);
          end
        end
        default: w_state_d = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Hour/minute/second setting controller: three button FSMs drive wrapping field
// registers, with 12/24 h hour presentation and an AM/PM flag derived combinationally.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       fmt12,
  input  logic       hours_btn,
  input  logic       mins_btn,
  input  logic       secs_btn,
  output logic [5:0] hours_o,
  output logic [5:0] mins_o,
  output logic [5:0] secs_o,
  output logic [1:0] A_P_o,
  output logic       changed_o
);

  logic [5:0] r_h24, r_m, r_s;
  logic       r_changed;
  logic       w_inc_h, w_inc_m, w_inc_s;
  logic [5:0] w_h_mod12;

  set_field_fsm #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_hours_fsm (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .btn   (hours_btn),
    .inc_o (w_inc_h)
  );

  set_field_fsm #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_mins_fsm (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .btn   (mins_btn),
    .inc_o (w_inc_m)
  );

  set_field_fsm #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_secs_fsm (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .btn   (secs_btn),
    .inc_o (w_inc_s)
  );

  // Fields wrap independently; there is deliberately no carry between them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h24     <= 6'd0;
      r_m       <= 6'd0;
      r_s       <= 6'd0;
      r_changed <= 1'b0;
    end else begin
      if (w_inc_h) r_h24 <= wrap_inc(r_h24, MAX_HOURS24);
      if (w_inc_m) r_m   <= wrap_inc(r_m, MAX_MINS);
      if (w_inc_s) r_s   <= wrap_inc(r_s, MAX_SECS);
      r_changed <= w_inc_h | w_inc_m | w_inc_s;
    end
  end

  always_comb begin
    w_h_mod12 = (r_h24 >= 6'd12) ? r_h24 - 6'd12 : r_h24;
    if (fmt12) begin
      hours_o = (w_h_mod12 == 6'd0) ? 6'd12 : w_h_mod12;
    end else begin
      hours_o = r_h24;
    end
    A_P_o = (r_h24 >= 6'd12) ? AP_PM : AP_AM;
  end

  assign mins_o    = r_m;
  assign secs_o    = r_s;
  assign changed_o = r_changed;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with short hold/repeat timing (8 / 4 cycles).
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       reset, enable, fmt12;
  logic       hours_btn, mins_btn, secs_btn;
  logic [5:0] hours_o, mins_o, secs_o;
  logic [1:0] A_P_o;
  logic       changed_o;

  int n_vec = 0;
  int n_err = 0;

  time_set_ctrl #(
    .HOLD_CYCLES  (8),
    .REPEAT_CYCLES(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .fmt12    (fmt12),
    .hours_btn(hours_btn),
    .mins_btn (mins_btn),
    .secs_btn (secs_btn),
    .hours_o  (hours_o),
    .mins_o   (mins_o),
    .secs_o   (secs_o),
    .A_P_o    (A_P_o),
    .changed_o(changed_o)
  );

  always #5 clk = ~clk;

  // Advance one active edge; inputs change and outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // which: 0 = hours, 1 = mins, 2 = secs. Each press is one cycle high, one low.
  task automatic press(input int which, input int n);
    for (int i = 0; i < n; i++) begin
      case (which)
        0: hours_btn = 1'b1;
        1: mins_btn  = 1'b1;
        default: secs_btn = 1'b1;
      endcase
      tick();
      hours_btn = 1'b0;
      mins_btn  = 1'b0;
      secs_btn  = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; fmt12 = 1'b0;
    hours_btn = 1'b0; mins_btn = 1'b0; secs_btn = 1'b0;
    tick(); tick();
    n_vec++;
    if (hours_o !== 6'd0 || mins_o !== 6'd0 || secs_o !== 6'd0 || A_P_o !== 2'b00
        || changed_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset24: h=%0d m=%0d s=%0d ap=%b chg=%b, required 0 0 0 00 0",
               hours_o, mins_o, secs_o, A_P_o, changed_o);
    end
    fmt12 = 1'b1;
    #1;
    n_vec++;
    if (hours_o !== 6'd12 || A_P_o !== 2'b00) begin
      n_err++;
      $display("FAIL reset12: h=%0d ap=%b, required 12 00", hours_o, A_P_o);
    end
    fmt12 = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_short_press();
    int pulses;
    enable   = 1'b1;
    mins_btn = 1'b1;
    tick();
    n_vec++;
    if (mins_o !== 6'd1 || changed_o !== 1'b1) begin
      n_err++;
      $display("FAIL short_first: m=%0d chg=%b, required 1 1", mins_o, changed_o);
    end
    pulses = 1;
    for (int i = 0; i < 7; i++) begin
      if (i == 2) mins_btn = 1'b0;
      tick();
      if (changed_o === 1'b1) pulses++;
    end
    n_vec++;
    if (mins_o !== 6'd1 || pulses != 1) begin
      n_err++;
      $display("FAIL short_once: m=%0d pulses=%0d, required 1 1", mins_o, pulses);
    end
  endtask

  task automatic test_auto_repeat();
    int exp_s;
    exp_s    = 0;
    secs_btn = 1'b1;
    for (int e = 0; e <= 20; e++) begin
      tick();
      if (e == 0 || (e >= 8 && (e - 8) % 4 == 0)) exp_s++;
      n_vec++;
      if (secs_o !== 6'(exp_s)) begin
        n_err++;
        $display("FAIL repeat_edge%0d: s=%0d, required %0d", e, secs_o, exp_s);
      end
    end
    secs_btn = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    n_vec++;
    if (secs_o !== 6'd5) begin
      n_err++;
      $display("FAIL repeat_release: s=%0d, required 5", secs_o);
    end
  endtask

  task automatic test_wrap_and_simultaneous();
    int pulses;
    press(0, 3);
    press(1, 58);
    n_vec++;
    if (mins_o !== 6'd59 || hours_o !== 6'd3) begin
      n_err++;
      $display("FAIL preload: m=%0d h=%0d, required 59 3", mins_o, hours_o);
    end
    mins_btn = 1'b1;
    tick();
    n_vec++;
    if (mins_o !== 6'd0 || hours_o !== 6'd3) begin
      n_err++;
      $display("FAIL min_wrap: m=%0d h=%0d, required 0 3", mins_o, hours_o);
    end
    mins_btn = 1'b0;
    tick();
    hours_btn = 1'b1;
    secs_btn  = 1'b1;
    tick();
    n_vec++;
    if (hours_o !== 6'd4 || secs_o !== 6'd6 || changed_o !== 1'b1) begin
      n_err++;
      $display("FAIL simul: h=%0d s=%0d chg=%b, required 4 6 1", hours_o, secs_o, changed_o);
    end
    pulses    = 1;
    hours_btn = 1'b0;
    secs_btn  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (changed_o === 1'b1) pulses++;
    end
    n_vec++;
    if (pulses != 1) begin
      n_err++;
      $display("FAIL simul_pulse: pulses=%0d, required 1", pulses);
    end
  endtask

  task automatic test_12h();
    fmt12 = 1'b1;
    press(0, 19);
    n_vec++;
    if (hours_o !== 6'd11 || A_P_o !== 2'b01) begin
      n_err++;
      $display("FAIL pm11: h=%0d ap=%b, required 11 01", hours_o, A_P_o);
    end
    hours_btn = 1'b1;
    tick();
    n_vec++;
    if (hours_o !== 6'd12 || A_P_o !== 2'b00) begin
      n_err++;
      $display("FAIL am12: h=%0d ap=%b, required 12 00", hours_o, A_P_o);
    end
    hours_btn = 1'b0;
    tick();
    fmt12 = 1'b0;
    #1;
    n_vec++;
    if (hours_o !== 6'd0 || A_P_o !== 2'b00) begin
      n_err++;
      $display("FAIL fmt24_midnight: h=%0d ap=%b, required 0 00", hours_o, A_P_o);
    end
    fmt12 = 1'b1;
    press(0, 11);
    n_vec++;
    if (hours_o !== 6'd11 || A_P_o !== 2'b00) begin
      n_err++;
      $display("FAIL am11: h=%0d ap=%b, required 11 00", hours_o, A_P_o);
    end
    press(0, 1);
    n_vec++;
    if (hours_o !== 6'd12 || A_P_o !== 2'b01) begin
      n_err++;
      $display("FAIL pm12: h=%0d ap=%b, required 12 01", hours_o, A_P_o);
    end
    fmt12 = 1'b0;
    #1;
    n_vec++;
    if (hours_o !== 6'd12 || A_P_o !== 2'b01) begin
      n_err++;
      $display("FAIL fmt24_noon: h=%0d ap=%b, required 12 01", hours_o, A_P_o);
    end
  endtask

  task automatic test_enable_and_reset();
    enable    = 1'b0;
    hours_btn = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    n_vec++;
    if (hours_o !== 6'd12 || changed_o !== 1'b0) begin
      n_err++;
      $display("FAIL disabled_press: h=%0d chg=%b, required 12 0", hours_o, changed_o);
    end
    enable = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    n_vec++;
    if (hours_o !== 6'd12 || changed_o !== 1'b0) begin
      n_err++;
      $display("FAIL enable_while_held: h=%0d chg=%b, required 12 0", hours_o, changed_o);
    end
    hours_btn = 1'b0;
    tick();
    hours_btn = 1'b1;
    tick();
    n_vec++;
    if (hours_o !== 6'd13) begin
      n_err++;
      $display("FAIL repress: h=%0d, required 13", hours_o);
    end
    tick(); tick();
    reset = 1'b1;
    #1;
    n_vec++;
    if (hours_o !== 6'd0 || mins_o !== 6'd0 || secs_o !== 6'd0 || A_P_o !== 2'b00
        || changed_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_hold: h=%0d m=%0d s=%0d ap=%b chg=%b, required 0 0 0 00 0",
               hours_o, mins_o, secs_o, A_P_o, changed_o);
    end
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    n_vec++;
    if (hours_o !== 6'd0 || changed_o !== 1'b0) begin
      n_err++;
      $display("FAIL held_after_reset: h=%0d chg=%b, required 0 0", hours_o, changed_o);
    end
    hours_btn = 1'b0;
    tick();
    hours_btn = 1'b1;
    tick();
    n_vec++;
    if (hours_o !== 6'd1) begin
      n_err++;
      $display("FAIL repress_after_reset: h=%0d, required 1", hours_o);
    end
    hours_btn = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_auto_repeat();
    test_wrap_and_simultaneous();
    test_12h();
    test_enable_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
